alu_mdu: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations at parametrised width, beside the existing combinational ALU in the execute stage. Uses one shared shift-add/restoring datapath, one result bit per cycle. Valid/ready handshakes on input and output let the pipeline stall on it. Divide-by-zero and signed overflow complete on a one-cycle fast path.

---
 rtl/cinco_mdu_pkg.sv | 27 ++
 rtl/alu_mdu.sv | 149 ++++++++++++++
 tb/tb_alu_mdu.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cinco_mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M funct3 encodings,
// FSM states and a small decode helper.
package cinco_mdu_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } mdu_state_e;

   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// datapath retiring one result bit per cycle, valid/ready on both sides.
module alu_mdu
   import cinco_mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_zero,
   output logic            busy
);

   localparam int unsigned CNT_W = $clog2(XLEN + 1);

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_q, op_d, op_in;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d;
   logic              neg_q, neg_d, dz_q, dz_d;

   logic              a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   assign op_in  = mdu_op_e'(op);
   assign a_sgn  = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
   assign b_sgn  = op_in inside {OpMulh, OpDiv, OpRem};
   assign a_neg  = a_sgn & a[XLEN-1];
   assign b_neg  = b_sgn & b[XLEN-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign b_zero = (b == '0);
   assign ovf    = (op_in inside {OpDiv, OpRem}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);

   // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; shift left, keep the difference
   // only when it does not borrow.
   assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign fix_res  = is_div(op_q)    ? (op_q[1] ? rem_fix : quo_fix) :
                     (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      if (kill) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_d = op_in;
                  dz_d = 1'b0;
                  if (is_div(op_in) && b_zero) begin
                     res_d   = op_in[1] ? a : '1;
                     dz_d    = 1'b1;
                     state_d = DONE;
                  end else if (ovf) begin
                     res_d   = op_in[1] ? '0 : a;
                     state_d = DONE;
                  end else begin
                     // Remainder follows the dividend; everything else the product/quotient.
                     neg_d   = (is_div(op_in) && op_in[1]) ? a_neg : (a_neg ^ b_neg);
                     acc_d   = {{XLEN{1'b0}}, is_div(op_in) ? a_mag : b_mag};
                     opnd_d  = is_div(op_in) ? b_mag : a_mag;
                     cnt_d   = CNT_W'(XLEN - 1);
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               acc_d = is_div(op_q) ? div_step : mul_step;
               if (cnt_q == '0) begin
                  state_d = FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            FIX: begin
               res_d   = fix_res;
               state_d = DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OpMul;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu against an arithmetic reference model
// built on the simulator's native signed/unsigned multiply and divide.
module tb_alu_mdu;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            kill = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      op = '0;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            div_zero;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   alu_mdu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kill      (kill),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // {div_zero, result} from RV32M semantics.
   function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx, sy, ux, uy;
      logic [63:0] p;
      sx = longint'(int'(x));
      sy = longint'(int'(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      case (o)
         3'd0: begin p = 64'(ux * uy); return {1'b0, p[31:0]}; end
         3'd1: begin p = 64'(sx * sy); return {1'b0, p[63:32]}; end
         3'd2: begin p = 64'(sx * uy); return {1'b0, p[63:32]}; end
         3'd3: begin p = 64'(ux * uy); return {1'b0, p[63:32]}; end
         3'd4: begin
            if (y == 0) return {1'b1, 32'hFFFF_FFFF};
            if (x == MIN_INT && y == 32'hFFFF_FFFF) return {1'b0, x};
            return {1'b0, 32'(int'(x) / int'(y))};
         end
         3'd5: begin
            if (y == 0) return {1'b1, 32'hFFFF_FFFF};
            return {1'b0, x / y};
         end
         3'd6: begin
            if (y == 0) return {1'b1, x};
            if (x == MIN_INT && y == 32'hFFFF_FFFF) return 33'd0;
            return {1'b0, 32'(int'(x) % int'(y))};
         end
         default: begin
            if (y == 0) return {1'b1, x};
            return {1'b0, x % y};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
      if (o[2] && y == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && x == MIN_INT && y == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
   endfunction

   // Issue one op, count edges to out_valid, optionally stall the consumer.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input logic early);
      logic [32:0] exp;
      logic [31:0] r0;
      int          n;
      exp = model(o, x, y);
      op = o; a = x; b = y; in_valid = 1'b1;
      check("in_ready_pre", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      out_ready = early;
      n = 1;
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), 64'(exp_lat(o, x, y)));
      check("result", 64'(result), 64'(exp[31:0]));
      check("div_zero", 64'(div_zero), 64'(exp[32]));
      r0 = result;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
         @(posedge clk); #1;
         check("hold_stable", 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, r0}));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("after_handshake", 64'({out_valid, in_ready}), 64'd1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return MIN_INT;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      int          rh;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_state", 64'({in_ready, out_valid, result, div_zero, busy}),
            64'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0}));

      // Reset in the middle of a multiply.
      op = 3'd0; a = 32'd7; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset", 64'({out_valid, in_ready, result}), 64'({1'b0, 1'b1, 32'd0}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);

      run_op(3'd1, MIN_INT, MIN_INT, 0, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 0, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 0, 1'b1);
      run_op(3'd5, 32'd5, 32'd0, 0, 1'b0);
      run_op(3'd7, 32'd5, 32'd0, 0, 1'b0);
      run_op(3'd4, MIN_INT, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, 0, 1'b0);

      // Backpressure with requests hammering the input.
      run_op(3'd5, 32'd100, 32'd7, 10, 1'b0);

      // Kill mid-divide together with a fresh request.
      op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 kill = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      check("kill_idle", 64'({out_valid, in_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
      repeat (3) @(posedge clk);
      #1 check("kill_quiet", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      run_op(3'd4, 32'd9, 32'd3, 0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = pick();
         ry = pick();
         rh = $urandom_range(0, 3);
         run_op(ro, rx, ry, rh, (rh == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
